// File: rtl/sram_burst_reader_pkg.sv
// Shared widths and burst FSM state encoding for the SRAM burst reader slice.
package typhoon_sram_pkg;

   localparam int SRAM_ADDR_W = 20;
   localparam int SRAM_DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      GUARD,
      WAIT,
      DRAIN_ABORT
   } burst_state_t;

   // Word addresses wrap modulo 2^20.
   function automatic logic [SRAM_ADDR_W-1:0] next_addr(input logic [SRAM_ADDR_W-1:0] a);
      return a + SRAM_ADDR_W'(1);
   endfunction

endpackage

// File: rtl/sram_burst_reader_if.sv
// One client port of the dual-clock SRAM controller; master is the requester side.
interface sram_burst_reader_if;
   import typhoon_sram_pkg::*;

   logic [SRAM_ADDR_W-1:0] AddressToSRAM;
   logic                   QueueReadReq;
   logic                   QueueWriteReq;
   logic [SRAM_DATA_W-1:0] DataToSRAM;
   logic                   DataReady;
   logic [SRAM_DATA_W-1:0] DataFromSRAM;

   modport master (
      output AddressToSRAM, QueueReadReq, QueueWriteReq, DataToSRAM,
      input  DataReady, DataFromSRAM
   );

   modport slave (
      input  AddressToSRAM, QueueReadReq, QueueWriteReq, DataToSRAM,
      output DataReady, DataFromSRAM
   );

endinterface

// File: rtl/sram_burst_reader_fifo.sv
// Synchronous show-ahead FIFO: head_o always shows the oldest word while not empty.
module sram_rd_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // Pops on empty are dropped here; flush overrides both push and pop.
   assign do_pop  = pop_i && !empty_o && !flush_i;
   assign do_push = push_i && !full_o && !flush_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/sram_burst_reader.sv
// Burst read initiator for one SRAM controller port: one outstanding single-word read at a
// time, returned words land in a show-ahead FIFO drained by a valid/ready consumer.
module sram_burst_reader
   import typhoon_sram_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int GUARD_CYCLES = 3,
   parameter int TIMEOUT      = 255,
   parameter int LEN_W        = 16
) (
   input  logic                   BOARD_CLK,
   input  logic                   RESET_N,
   input  logic                   START,
   input  logic [SRAM_ADDR_W-1:0] START_ADDR,
   input  logic [LEN_W-1:0]       LENGTH,
   input  logic                   ABORT,
   output logic                   BUSY,
   output logic                   DONE,
   output logic                   ERROR,
   output logic [SRAM_DATA_W-1:0] OUT_DATA,
   output logic                   OUT_VALID,
   input  logic                   OUT_READY,
   output burst_state_t           DBG_STATE,
   sram_burst_reader_if.master    sram
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int G_W   = $clog2(GUARD_CYCLES + 2);
   localparam int T_W   = $clog2(TIMEOUT + 1);

   burst_state_t           state_q, state_d;
   logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]       rem_q, rem_d;
   logic [G_W-1:0]         guard_q, guard_d;
   logic [T_W-1:0]         tmo_q, tmo_d;
   logic                   error_q, error_d;
   logic                   done_q, done_d;
   logic [1:0]             sync_q;

   logic                   rdy_s;
   logic [G_W-1:0]         guard_inc;
   logic                   guard_done;
   logic                   tmo_hit;
   logic                   req;
   logic                   fifo_push;
   logic                   fifo_flush;
   logic [CNT_W-1:0]       fifo_count;
   logic                   fifo_empty;
   logic                   fifo_full;

   // DataReady comes from the SRAM_CLK domain; DataFromSRAM is only looked at once rdy_s is high.
   assign rdy_s      = sync_q[1];
   assign guard_inc  = guard_q + G_W'(1);
   assign guard_done = (guard_q == G_W'(GUARD_CYCLES));
   assign tmo_hit    = (tmo_q == T_W'(TIMEOUT - 1));

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      guard_d    = guard_q;
      tmo_d      = tmo_q;
      error_d    = error_q;
      done_d     = 1'b0;
      req        = 1'b0;
      fifo_push  = 1'b0;
      fifo_flush = 1'b0;
      case (state_q)
         IDLE: begin
            if (ABORT) begin
               fifo_flush = 1'b1;
            end else if (START) begin
               if (LENGTH == '0) begin
                  done_d = 1'b1;
               end else begin
                  addr_d  = START_ADDR;
                  rem_d   = LENGTH;
                  error_d = 1'b0;
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            // Holding back until a slot is free guarantees the in-flight word always fits.
            if (ABORT) begin
               fifo_flush = 1'b1;
               state_d    = IDLE;
            end else if (fifo_count < CNT_W'(DEPTH)) begin
               req     = 1'b1;
               guard_d = '0;
               tmo_d   = '0;
               state_d = (GUARD_CYCLES == 0) ? WAIT : GUARD;
            end
         end
         GUARD: begin
            guard_d = guard_inc;
            if (ABORT) begin
               fifo_flush = 1'b1;
               state_d    = DRAIN_ABORT;
            end else if (guard_inc == G_W'(GUARD_CYCLES)) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (ABORT) begin
               fifo_flush = 1'b1;
               state_d    = DRAIN_ABORT;
            end else if (rdy_s) begin
               fifo_push = 1'b1;
               addr_d    = next_addr(addr_q);
               rem_d     = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = ISSUE;
               end
            end else if (tmo_hit) begin
               error_d = 1'b1;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + T_W'(1);
            end
         end
         DRAIN_ABORT: begin
            // Finish the guard window first so a stale ready cannot end the drain early.
            if (!guard_done) begin
               guard_d = guard_inc;
            end else if (rdy_s || tmo_hit) begin
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + T_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         guard_q <= '0;
         tmo_q   <= '0;
         error_q <= 1'b0;
         done_q  <= 1'b0;
         sync_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         guard_q <= guard_d;
         tmo_q   <= tmo_d;
         error_q <= error_d;
         done_q  <= done_d;
         sync_q  <= {sync_q[0], sram.DataReady};
      end
   end

   always_ff @(posedge BOARD_CLK) begin
      if (RESET_N && fifo_push) assert (!fifo_full);
   end

   // Output stream: a word moves on each rising edge with OUT_VALID && OUT_READY; OUT_VALID
   // never depends on OUT_READY and the head word is stable until it is taken.
   sram_rd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (SRAM_DATA_W)
   ) u_fifo (
      .clk_i       (BOARD_CLK),
      .rst_ni      (RESET_N),
      .flush_i     (fifo_flush),
      .push_i      (fifo_push),
      .push_data_i (sram.DataFromSRAM),
      .pop_i       (OUT_READY),
      .head_o      (OUT_DATA),
      .count_o     (fifo_count),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full)
   );

   assign OUT_VALID          = !fifo_empty;
   assign BUSY               = (state_q != IDLE);
   assign DONE               = done_q;
   assign ERROR              = error_q;
   assign DBG_STATE          = state_q;
   assign sram.QueueReadReq  = req;
   assign sram.AddressToSRAM = addr_q;
   assign sram.QueueWriteReq = 1'b0;
   assign sram.DataToSRAM    = '0;

endmodule

// File: tb/tb_sram_burst_reader.sv
// Directed bench for sram_burst_reader with a 4-cycle SRAM port responder model.
module tb_sram_burst_reader;
  import typhoon_sram_pkg::*;

  localparam int DEPTH  = 8;
  localparam int GUARD  = 3;
  localparam int TMO    = 255;
  localparam int LEN_W  = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              start = 1'b0;
  logic [19:0]       start_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              abort = 1'b0;
  logic              out_ready = 1'b1;
  logic              busy, done, error, out_valid;
  logic [15:0]       out_data;
  burst_state_t      dbg_state;

  sram_burst_reader_if sram_bus ();

  sram_burst_reader #(
    .DEPTH(DEPTH), .GUARD_CYCLES(GUARD), .TIMEOUT(TMO), .LEN_W(LEN_W)
  ) dut (
    .BOARD_CLK(clk), .RESET_N(rst_n), .START(start), .START_ADDR(start_addr),
    .LENGTH(length), .ABORT(abort), .BUSY(busy), .DONE(done), .ERROR(error),
    .OUT_DATA(out_data), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .DBG_STATE(dbg_state), .sram(sram_bus)
  );

  function automatic logic [15:0] mem_word(input logic [19:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  // responder: a request drops DataReady, data returns 4 cycles later and is held
  bit          resp_en = 1'b1;
  int          pend;
  logic [19:0] pend_addr;
  initial begin
    sram_bus.DataReady = 1'b0;
    sram_bus.DataFromSRAM = '0;
    pend = -1;
    pend_addr = '0;
    forever begin
      @(negedge clk);
      if (sram_bus.QueueReadReq) begin
        sram_bus.DataReady = 1'b0;
        pend = 4;
        pend_addr = sram_bus.AddressToSRAM;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0 && resp_en) begin
          sram_bus.DataFromSRAM = mem_word(pend_addr);
          sram_bus.DataReady = 1'b1;
        end
      end
    end
  end

  // monitor
  logic [19:0] req_q[$];
  int          req_cyc_q[$];
  logic [15:0] got_q[$];
  int          req_cnt = 0;
  int          done_cnt = 0;
  always @(negedge clk) begin
    if (sram_bus.QueueReadReq) begin
      req_q.push_back(sram_bus.AddressToSRAM);
      req_cyc_q.push_back(cyc);
      req_cnt++;
    end
    if (done) done_cnt++;
    if (out_valid && out_ready) got_q.push_back(out_data);
  end

  // scoreboard
  int          n_vec = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  int          start_cyc = 0;
  int          base_req, base_got, base_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [19:0] a, input logic [LEN_W-1:0] n);
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; length = n; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic mark();
    base_req = req_cnt; base_got = got_q.size(); base_done = done_cnt;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (done_cnt == base_done && k < budget) begin tick(1); k++; end
    check(name, 32'(done_cnt - base_done), 32'd1);
  endtask

  task automatic wait_reqs(input int n, input int budget);
    int k = 0;
    while (req_cnt - base_req < n && k < budget) begin tick(1); k++; end
  endtask

  // compares addresses and data of a finished burst against the model
  task automatic check_burst(input string tag, input logic [19:0] a0, input int len);
    logic [19:0] a;
    logic [31:0] ga, gd;
    check({tag, "_nreq"}, 32'(req_cnt - base_req), 32'(len));
    check({tag, "_nword"}, 32'(got_q.size() - base_got), 32'(len));
    a = a0;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(mem_word(a));
      ga = (base_req + i < req_q.size()) ? 32'(req_q[base_req + i]) : 32'hFFFF_FFFF;
      check($sformatf("%s_addr%0d", tag, i), ga, 32'(a));
      a = next_addr(a);
    end
    for (int i = 0; i < len; i++) begin
      gd = (base_got + i < got_q.size()) ? 32'(got_q[base_got + i]) : 32'hFFFF_FFFF;
      check($sformatf("%s_data%0d", tag, i), gd, 32'(exp_q.pop_front()));
    end
  endtask

  typedef struct {
    logic [19:0]      addr;
    logic [LEN_W-1:0] len;
    logic [15:0]      exp_first_data;
    logic [19:0]      exp_last_addr;
  } vec_t;
  vec_t vecs[4];

  initial begin
    int k;
    vecs[0] = '{20'h00010, 16'd4, 16'hA5B5, 20'h00013};
    vecs[1] = '{20'hFFFFE, 16'd3, 16'h5A5B, 20'h00000};
    vecs[2] = '{20'hFFFFF, 16'd2, 16'h5A5A, 20'h00000};
    vecs[3] = '{20'h12345, 16'd1, 16'h86E0, 20'h12345};

    tick(3);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_req", 32'(sram_bus.QueueReadReq), 0);
    check("rst_addr", 32'(sram_bus.AddressToSRAM), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    tick(2);

    for (int v = 0; v < 4; v++) begin
      mark();
      out_ready = 1'b1;
      start_burst(vecs[v].addr, vecs[v].len);
      check($sformatf("v%0d_busy_run", v), 32'(busy), 1);
      wait_done($sformatf("v%0d_done", v), 300);
      tick(3);
      check($sformatf("v%0d_latency", v),
            (req_cyc_q.size() > base_req) ? 32'(req_cyc_q[base_req] - start_cyc) : 32'hFFFF_FFFF, 1);
      check($sformatf("v%0d_first", v),
            (got_q.size() > base_got) ? 32'(got_q[base_got]) : 32'hFFFF_FFFF, 32'(vecs[v].exp_first_data));
      check($sformatf("v%0d_last", v), 32'(req_q[req_q.size() - 1]), 32'(vecs[v].exp_last_addr));
      check_burst($sformatf("v%0d", v), vecs[v].addr, int'(vecs[v].len));
      check($sformatf("v%0d_busy_end", v), 32'(busy), 0);
      check($sformatf("v%0d_ndone", v), 32'(done_cnt - base_done), 1);
    end

    // back-pressure: FIFO fills, ISSUE stalls, then drains
    mark();
    out_ready = 1'b0;
    start_burst(20'h00300, 16'd12);
    wait_reqs(8, 200);
    tick(40);
    check("stall_nreq", 32'(req_cnt - base_req), 8);
    check("stall_valid", 32'(out_valid), 1);
    check("stall_state", 32'(dbg_state), 32'(ISSUE));
    check("stall_busy", 32'(busy), 1);
    out_ready = 1'b1;
    wait_done("stall_done", 400);
    tick(3);
    check_burst("stall", 20'h00300, 12);

    // timeout: responder stays silent
    mark();
    resp_en = 1'b0;
    start_burst(20'h00040, 16'd2);
    k = 0;
    while (!error && k < 400) begin tick(1); k++; end
    check("tmo_latency", (req_cyc_q.size() > base_req) ? 32'(cyc - req_cyc_q[base_req]) : 32'hFFFF_FFFF,
          32'(1 + GUARD + TMO));
    check("tmo_busy", 32'(busy), 0);
    check("tmo_nreq", 32'(req_cnt - base_req), 1);
    tick(2);
    check("tmo_sticky", 32'(error), 1);
    check("tmo_ndone", 32'(done_cnt - base_done), 0);
    resp_en = 1'b1;
    mark();
    start_burst(20'h00050, 16'd1);
    check("tmo_err_clear", 32'(error), 0);
    wait_done("tmo_next_done", 200);
    tick(2);
    check_burst("tmo_next", 20'h00050, 1);

    // abort during WAIT of word 2 of 6
    mark();
    out_ready = 1'b0;
    start_burst(20'h00200, 16'd6);
    wait_reqs(2, 100);
    tick(3);
    check("abort_pre_state", 32'(dbg_state), 32'(WAIT));
    check("abort_pre_valid", 32'(out_valid), 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_busy_drain", 32'(busy), 1);
    check("abort_flushed", 32'(out_valid), 0);
    k = 0;
    while (busy && k < 400) begin tick(1); k++; end
    check("abort_idle", 32'(busy), 0);
    tick(20);
    check("abort_nreq", 32'(req_cnt - base_req), 2);
    check("abort_ndone", 32'(done_cnt - base_done), 0);
    check("abort_valid_end", 32'(out_valid), 0);
    check("abort_nword", 32'(got_q.size() - base_got), 0);

    // zero-length start
    mark();
    out_ready = 1'b1;
    start_burst(20'h00777, 16'd0);
    check("len0_done", 32'(done), 1);
    check("len0_busy", 32'(busy), 0);
    tick(10);
    check("len0_nreq", 32'(req_cnt - base_req), 0);
    check("len0_ndone", 32'(done_cnt - base_done), 1);

    // asynchronous reset mid-burst
    mark();
    out_ready = 1'b0;
    start_burst(20'h00400, 16'd5);
    wait_reqs(2, 100);
    tick(2);
    #3 rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_done", 32'(done), 0);
    check("mrst_error", 32'(error), 0);
    check("mrst_valid", 32'(out_valid), 0);
    check("mrst_req", 32'(sram_bus.QueueReadReq), 0);
    check("mrst_addr", 32'(sram_bus.AddressToSRAM), 0);
    check("mrst_state", 32'(dbg_state), 32'(IDLE));
    tick(2);
    rst_n = 1'b1;
    tick(10);

    // recovery burst after reset
    mark();
    out_ready = 1'b1;
    start_burst(20'h00500, 16'd2);
    wait_done("recov_done", 200);
    tick(3);
    check_burst("recov", 20'h00500, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
